// File: rtl/clock_div_bank.sv
// Bank of programmable clock dividers with per-channel period/high-time and glitch-free
// reconfiguration: new settings take effect only at a period boundary, on sync, or while disabled.
module clock_div_bank #(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEF_PERIOD = 12500,
    localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_en,
    input  logic             sync,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(DEF_PERIOD / 2);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(2);

    // Active and shadow configuration per channel
    logic [CNT_W-1:0] act_p_q [N_CH];
    logic [CNT_W-1:0] act_p_d [N_CH];
    logic [CNT_W-1:0] act_h_q [N_CH];
    logic [CNT_W-1:0] act_h_d [N_CH];
    logic [N_CH-1:0]  act_en_q, act_en_d;

    logic [CNT_W-1:0] sh_p_q [N_CH];
    logic [CNT_W-1:0] sh_p_d [N_CH];
    logic [CNT_W-1:0] sh_h_q [N_CH];
    logic [CNT_W-1:0] sh_h_d [N_CH];
    logic [N_CH-1:0]  sh_en_q, sh_en_d;

    logic [N_CH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] ph_q [N_CH];
    logic [CNT_W-1:0] ph_d [N_CH];

    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic             cfg_err_q, cfg_err_d;

    // Low for the first cycle after reset so every channel starts cleanly at ph = 0
    logic             run_q;

    logic             cfg_valid;
    logic [N_CH-1:0]  running, wrap, restart, apply, wr_hit;

    always_comb begin
        cfg_valid = cfg_we && (32'(cfg_ch) < N_CH) && (cfg_period >= MinPeriod);
        cfg_err_d = cfg_we && !cfg_valid;

        running   = '0;
        wrap      = '0;
        restart   = '0;
        apply     = '0;
        wr_hit    = '0;
        act_p_d   = act_p_q;
        act_h_d   = act_h_q;
        act_en_d  = act_en_q;
        sh_p_d    = sh_p_q;
        sh_h_d    = sh_h_q;
        sh_en_d   = sh_en_q;
        pend_d    = pend_q;
        ph_d      = ph_q;
        clk_out_d = '0;
        tick_d    = '0;

        for (int unsigned i = 0; i < N_CH; i++) begin
            running[i] = run_q && act_en_q[i];
            wrap[i]    = running[i] && (ph_q[i] >= act_p_q[i] - CntOne);
            restart[i] = running[i] && (wrap[i] || sync);
            // A running channel only swaps config at a boundary; an idle one swaps at once
            apply[i]   = pend_q[i] && (restart[i] || !running[i]);
            wr_hit[i]  = cfg_valid && (cfg_ch == CH_W'(i));

            if (apply[i]) begin
                act_p_d[i]  = sh_p_q[i];
                act_h_d[i]  = sh_h_q[i];
                act_en_d[i] = sh_en_q[i];
                pend_d[i]   = 1'b0;
            end

            // Uses the prior shadow for any apply above; the new write waits for the next one
            if (wr_hit[i]) begin
                sh_p_d[i]  = cfg_period;
                sh_h_d[i]  = cfg_high;
                sh_en_d[i] = cfg_en;
                pend_d[i]  = 1'b1;
            end

            if (!act_en_d[i] || !running[i] || restart[i]) begin
                ph_d[i] = '0;
            end else begin
                ph_d[i] = ph_q[i] + CntOne;
            end

            // Registered together with ph so each output bit comes straight from a flop
            tick_d[i]    = act_en_d[i] && (ph_d[i] == '0);
            clk_out_d[i] = act_en_d[i] && (ph_d[i] < act_h_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q     <= 1'b0;
            act_en_q  <= '1;
            sh_en_q   <= '1;
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                act_p_q[i] <= DefPeriod;
                act_h_q[i] <= DefHigh;
                sh_p_q[i]  <= DefPeriod;
                sh_h_q[i]  <= DefHigh;
                ph_q[i]    <= '0;
            end
        end else begin
            run_q     <= 1'b1;
            act_p_q   <= act_p_d;
            act_h_q   <= act_h_d;
            act_en_q  <= act_en_d;
            sh_p_q    <= sh_p_d;
            sh_h_q    <= sh_h_d;
            sh_en_q   <= sh_en_d;
            pend_q    <= pend_d;
            ph_q      <= ph_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pending = pend_q;
    assign cfg_err = cfg_err_q;

endmodule
